// File: rtl/ai_pkg.sv
// Shared default widths, write-response encodings and the master-index width helper
// for the slave-side write arbitration path.
package ai_pkg;

  localparam int unsigned DEF_MST_AMT           = 2;
  localparam int unsigned DEF_DATA_WIDTH        = 32;
  localparam int unsigned DEF_ADDR_WIDTH        = 32;
  localparam int unsigned DEF_TRANS_MST_ID_W    = 5;
  localparam int unsigned DEF_TRANS_DATA_LEN_W  = 3;
  localparam int unsigned DEF_TRANS_DATA_SIZE_W = 3;
  localparam int unsigned DEF_TRANS_WR_RESP_W   = 2;
  localparam int unsigned DEF_ORDER_FIFO_DEPTH  = 4;
  localparam int unsigned DEF_MAX_OUTSTANDING   = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bits needed to name one of n masters; never narrower than one bit.
  function automatic int unsigned mst_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_MST_ID_W = mst_id_width(DEF_MST_AMT);

endpackage

// File: rtl/ai_sa_order_fifo.sv
// Synchronous FIFO recording AW grant order so W beats follow the granted master.
// Entries are master indices; DEPTH must be a power of 2.
module ai_sa_order_fifo
  import ai_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_ORDER_FIFO_DEPTH,
  parameter int unsigned WIDTH = DEF_MST_ID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (32'(count) == DEPTH);
  assign empty = (count == '0);

endmodule

// File: rtl/ai_sa_write_arbiter.sv
// Slave-port write arbiter: round-robin AW grant with master index prepended to the ID,
// W routing in grant order, B demux by upper ID bits. AI_SA_OUTSTANDING_LIMIT_EN adds a write cap.
module ai_sa_write_arbiter
  import ai_pkg::*;
#(
  parameter int unsigned MST_AMT           = DEF_MST_AMT,
  parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int unsigned TRANS_MST_ID_W    = DEF_TRANS_MST_ID_W,
  parameter int unsigned TRANS_DATA_LEN_W  = DEF_TRANS_DATA_LEN_W,
  parameter int unsigned TRANS_DATA_SIZE_W = DEF_TRANS_DATA_SIZE_W,
  parameter int unsigned TRANS_WR_RESP_W   = DEF_TRANS_WR_RESP_W,
  parameter int unsigned ORDER_FIFO_DEPTH  = DEF_ORDER_FIFO_DEPTH,
  parameter int unsigned MAX_OUTSTANDING   = DEF_MAX_OUTSTANDING,
  localparam int unsigned MST_ID_W         = mst_id_width(MST_AMT),
  localparam int unsigned S_ID_W           = TRANS_MST_ID_W + MST_ID_W
) (
  input  logic                                    ACLK_i,
  input  logic                                    ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]       dsp_AWID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]           dsp_AWADDR_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]     dsp_AWLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]    dsp_AWSIZE_i,
  input  logic [MST_AMT-1:0]                      dsp_AWVALID_i,
  output logic [MST_AMT-1:0]                      dsp_AWREADY_o,
  input  logic [DATA_WIDTH*MST_AMT-1:0]           dsp_WDATA_i,
  input  logic [MST_AMT-1:0]                      dsp_WLAST_i,
  input  logic [MST_AMT-1:0]                      dsp_WVALID_i,
  output logic [MST_AMT-1:0]                      dsp_WREADY_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]       dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]      dsp_BRESP_o,
  output logic [MST_AMT-1:0]                      dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                      dsp_BREADY_i,
  output logic [S_ID_W-1:0]                       s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                   s_AWADDR_o,
  output logic [TRANS_DATA_LEN_W-1:0]             s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]            s_AWSIZE_o,
  output logic                                    s_AWVALID_o,
  input  logic                                    s_AWREADY_i,
  output logic [DATA_WIDTH-1:0]                   s_WDATA_o,
  output logic                                    s_WLAST_o,
  output logic                                    s_WVALID_o,
  input  logic                                    s_WREADY_i,
  input  logic [S_ID_W-1:0]                       s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]              s_BRESP_i,
  input  logic                                    s_BVALID_i,
  output logic                                    s_BREADY_o
);

  if (ORDER_FIFO_DEPTH == 0 || (ORDER_FIFO_DEPTH & (ORDER_FIFO_DEPTH - 1)) != 0 ||
      MAX_OUTSTANDING == 0) begin : g_bad_cfg
    $error("ai_sa_write_arbiter: ORDER_FIFO_DEPTH must be a power of 2, MAX_OUTSTANDING nonzero");
  end

  typedef enum logic {AW_IDLE, AW_HOLD} aw_state_e;

  aw_state_e           state_q, state_d;
  logic [MST_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [MST_ID_W-1:0] grant_idx;
  logic                grant_c;
  logic                grant_allow;
  int unsigned         scan;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [MST_ID_W-1:0] fifo_head;

  logic [TRANS_MST_ID_W-1:0]    aw_id   [MST_AMT];
  logic [ADDR_WIDTH-1:0]        aw_addr [MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  aw_len  [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] aw_size [MST_AMT];
  logic [DATA_WIDTH-1:0]        w_data  [MST_AMT];

  for (genvar m = 0; m < MST_AMT; m++) begin : g_slice
    assign aw_id[m]   = dsp_AWID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign aw_addr[m] = dsp_AWADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_len[m]  = dsp_AWLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    assign aw_size[m] = dsp_AWSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    assign w_data[m]  = dsp_WDATA_i[m*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef AI_SA_OUTSTANDING_LIMIT_EN
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [OUT_W-1:0] out_cnt_q;
  logic             b_hs;

  assign b_hs = s_BVALID_i & s_BREADY_o;

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      out_cnt_q <= '0;
    end else if (grant_c && !b_hs) begin
      out_cnt_q <= out_cnt_q + OUT_W'(1);
    end else if (!grant_c && b_hs && out_cnt_q != '0) begin
      out_cnt_q <= out_cnt_q - OUT_W'(1);
    end
  end

  assign grant_allow = !ARESET_i && !fifo_full && (32'(out_cnt_q) != MAX_OUTSTANDING);
`else
  assign grant_allow = !ARESET_i && !fifo_full;
`endif

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q  <= AW_IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Descending scan so the requester closest at/after the pointer is the final winner.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_c       = 1'b0;
    grant_idx     = '0;
    scan          = 0;
    dsp_AWREADY_o = '0;
    case (state_q)
      AW_IDLE: begin
        if (grant_allow) begin
          for (int i = int'(MST_AMT) - 1; i >= 0; i--) begin
            scan = 32'(rr_ptr_q) + 32'(i);
            if (scan >= MST_AMT) scan = scan - MST_AMT;
            if (dsp_AWVALID_i[MST_ID_W'(scan)]) begin
              grant_c   = 1'b1;
              grant_idx = MST_ID_W'(scan);
            end
          end
          if (grant_c) begin
            dsp_AWREADY_o[grant_idx] = 1'b1;
            rr_ptr_d = (32'(grant_idx) == MST_AMT - 1) ? '0 : grant_idx + MST_ID_W'(1);
            state_d  = AW_HOLD;
          end
        end
      end
      AW_HOLD: begin
        if (s_AWREADY_i) state_d = AW_IDLE;
      end
      default: state_d = AW_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      s_AWVALID_o <= 1'b0;
      s_AWID_o    <= '0;
      s_AWADDR_o  <= '0;
      s_AWLEN_o   <= '0;
      s_AWSIZE_o  <= '0;
    end else begin
      s_AWVALID_o <= (state_d == AW_HOLD);
      if (grant_c) begin
        s_AWID_o   <= {grant_idx, aw_id[grant_idx]};
        s_AWADDR_o <= aw_addr[grant_idx];
        s_AWLEN_o  <= aw_len[grant_idx];
        s_AWSIZE_o <= aw_size[grant_idx];
      end
    end
  end

  ai_sa_order_fifo #(
    .DEPTH (ORDER_FIFO_DEPTH),
    .WIDTH (MST_ID_W)
  ) u_order_fifo (
    .clk       (ACLK_i),
    .rst       (ARESET_i),
    .push      (grant_c),
    .push_data (grant_idx),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // W beats only flow for the master whose AW grant is oldest.
  always_comb begin
    s_WVALID_o   = 1'b0;
    s_WDATA_o    = '0;
    s_WLAST_o    = 1'b0;
    dsp_WREADY_o = '0;
    if (!ARESET_i && !fifo_empty) begin
      for (int unsigned m = 0; m < MST_AMT; m++) begin
        if (32'(fifo_head) == m) begin
          s_WVALID_o      = dsp_WVALID_i[m];
          s_WDATA_o       = w_data[m];
          s_WLAST_o       = dsp_WLAST_i[m];
          dsp_WREADY_o[m] = s_WREADY_i;
        end
      end
    end
  end

  assign fifo_pop = s_WVALID_o & s_WREADY_i & s_WLAST_o;

  // Responses whose master field names no existing master are accepted and dropped.
  always_comb begin
    dsp_BVALID_o = '0;
    dsp_BID_o    = '0;
    dsp_BRESP_o  = '0;
    s_BREADY_o   = !ARESET_i;
    if (!ARESET_i) begin
      for (int unsigned m = 0; m < MST_AMT; m++) begin
        if (32'(s_BID_i[S_ID_W-1 -: MST_ID_W]) == m) begin
          dsp_BVALID_o[m] = s_BVALID_i;
          dsp_BID_o[m*TRANS_MST_ID_W +: TRANS_MST_ID_W]   = s_BID_i[TRANS_MST_ID_W-1:0];
          dsp_BRESP_o[m*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = s_BRESP_i;
          s_BREADY_o = dsp_BREADY_i[m];
        end
      end
    end
  end

endmodule
